// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control FSM and the shared
// instruction/data memory.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_sel;
   logic mem_we;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_sel,
      output mem_we,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_sel,
      input  mem_we,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EX/MEM/WB with memory wait/timeout.
// Optional perf counters are built only when CTRL_PERF_EN is defined.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   multicycle_ctrl_if.master      mem_bus,
   input  logic [5:0]             instr_op_i,
   input  logic                   zero_i,
   output logic                   ir_write_o,
   output logic                   pc_write_o,
   output logic                   pc_src_o,
   output logic                   reg_write_o,
   output logic                   reg_dst_o,
   output logic                   mem_to_reg_o,
   output logic                   alu_src_o,
   output logic                   sign_ext_o,
   output logic [3:0]             alu_op_o,
   output logic [2:0]             state_o,
   output logic                   halt_o,
   output logic                   err_o,
   output logic [31:0]            instr_cnt_o,
   output logic [31:0]            cycle_cnt_o
);

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd7
   } state_e;

   localparam logic [5:0] OpR     = 6'd0;
   localparam logic [5:0] OpBeq   = 6'd4;
   localparam logic [5:0] OpBne   = 6'd5;
   localparam logic [5:0] OpAddi  = 6'd8;
   localparam logic [5:0] OpSltiu = 6'd9;
   localparam logic [5:0] OpSlti  = 6'd10;
   localparam logic [5:0] OpOri   = 6'd13;
   localparam logic [5:0] OpLw    = 6'd35;
   localparam logic [5:0] OpSw    = 6'd43;
   localparam logic [5:0] OpHalt  = 6'h3F;

   localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);
   localparam int unsigned WaitW     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitLast =
      WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic             err_q, err_d;
   logic             retire;
   logic             timed_out;

   // The cycle that would bring the wait count up to MEM_TIMEOUT is the last one allowed.
   assign timed_out = TimeoutEn && !mem_bus.mem_ready && (wait_q == WaitLast);

   always_comb begin
      state_d          = state_q;
      wait_d           = '0;
      err_d            = err_q;
      retire           = 1'b0;
      mem_bus.mem_req  = 1'b0;
      mem_bus.mem_sel  = 1'b0;
      mem_bus.mem_we   = 1'b0;
      ir_write_o       = 1'b0;
      pc_write_o       = 1'b0;
      pc_src_o         = 1'b0;
      reg_write_o      = 1'b0;
      reg_dst_o        = 1'b0;
      mem_to_reg_o     = 1'b0;
      alu_src_o        = 1'b0;
      sign_ext_o       = 1'b0;
      alu_op_o         = 4'b0000;

      case (state_q)
         StIf: begin
            mem_bus.mem_req = 1'b1;
            if (mem_bus.mem_ready) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = StId;
            end else if (timed_out) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else if (TimeoutEn) begin
               wait_d = wait_q + WaitW'(1);
            end
         end

         StId: begin
            case (instr_op_i)
               OpR, OpBeq, OpBne, OpAddi, OpSltiu, OpSlti, OpOri, OpLw, OpSw: state_d = StEx;
               OpHalt:  state_d = StHalt;
               default: begin
                  state_d = StHalt;
                  err_d   = 1'b1;
               end
            endcase
         end

         StEx: begin
            sign_ext_o = 1'b1;
            case (instr_op_i)
               OpR:          alu_op_o = 4'b0010;
               OpBeq, OpBne: alu_op_o = 4'b0001;
               OpAddi, OpLw, OpSw: begin
                  alu_op_o  = 4'b0000;
                  alu_src_o = 1'b1;
               end
               OpSlti: begin
                  alu_op_o  = 4'b0011;
                  alu_src_o = 1'b1;
               end
               OpSltiu: begin
                  alu_op_o   = 4'b0101;
                  alu_src_o  = 1'b1;
                  sign_ext_o = 1'b0;
               end
               OpOri: begin
                  alu_op_o   = 4'b0100;
                  alu_src_o  = 1'b1;
                  sign_ext_o = 1'b0;
               end
               default: ;
            endcase

            if (instr_op_i == OpBeq || instr_op_i == OpBne) begin
               // beq takes on zero, bne on non-zero
               if ((instr_op_i == OpBeq) ? zero_i : !zero_i) begin
                  pc_write_o = 1'b1;
                  pc_src_o   = 1'b1;
               end
               retire  = 1'b1;
               state_d = StIf;
            end else if (instr_op_i == OpLw || instr_op_i == OpSw) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end

         StMem: begin
            mem_bus.mem_req = 1'b1;
            mem_bus.mem_sel = 1'b1;
            mem_bus.mem_we  = (instr_op_i == OpSw);
            if (mem_bus.mem_ready) begin
               if (instr_op_i == OpSw) begin
                  retire  = 1'b1;
                  state_d = StIf;
               end else begin
                  state_d = StWb;
               end
            end else if (timed_out) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else if (TimeoutEn) begin
               wait_d = wait_q + WaitW'(1);
            end
         end

         StWb: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = (instr_op_i == OpR);
            mem_to_reg_o = (instr_op_i == OpLw);
            retire       = 1'b1;
            state_d      = StIf;
         end

         StHalt: state_d = StHalt;

         default: begin
            state_d = StHalt;
            err_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIf;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign state_o = state_q;
   assign halt_o  = (state_q == StHalt);
   assign err_o   = err_q;

`ifdef CTRL_PERF_EN
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      instr_cnt_d = instr_cnt_q + {31'd0, retire};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_cnt_q <= 32'd0;
         cycle_cnt_q <= 32'd0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign instr_cnt_o = instr_cnt_q;
   assign cycle_cnt_o = cycle_cnt_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign instr_cnt_o   = 32'd0;
   assign cycle_cnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model plans every cycle's inputs and
// expected outputs; a driver applies them and a negedge monitor compares.
module tb_multicycle_ctrl;

   localparam int unsigned TB_TIMEOUT = 4;
`ifdef CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [10:0] MREQ  = 11'h400;
   localparam logic [10:0] MSEL  = 11'h200;
   localparam logic [10:0] MWE   = 11'h100;
   localparam logic [10:0] IRW   = 11'h080;
   localparam logic [10:0] PCW   = 11'h040;
   localparam logic [10:0] PCSRC = 11'h020;
   localparam logic [10:0] REGW  = 11'h010;
   localparam logic [10:0] RDST  = 11'h008;
   localparam logic [10:0] M2R   = 11'h004;
   localparam logic [10:0] ASRC  = 11'h002;
   localparam logic [10:0] SEXT  = 11'h001;

   typedef struct {
      logic        rst;
      logic        ready;
      logic        zero;
      logic [5:0]  op;
      bit          chk;
      logic [2:0]  st;
      logic [10:0] ctl;
      logic [3:0]  aop;
      logic        halt;
      logic        err;
      logic [31:0] icnt;
      logic [31:0] ccnt;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op;
   logic        zero;
   logic        ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src, sign_ext;
   logic [3:0]  alu_op;
   logic [2:0]  state;
   logic        halt, err;
   logic [31:0] instr_cnt, cycle_cnt;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .mem_bus     (bus),
      .instr_op_i  (op),
      .zero_i      (zero),
      .ir_write_o  (ir_write),
      .pc_write_o  (pc_write),
      .pc_src_o    (pc_src),
      .reg_write_o (reg_write),
      .reg_dst_o   (reg_dst),
      .mem_to_reg_o(mem_to_reg),
      .alu_src_o   (alu_src),
      .sign_ext_o  (sign_ext),
      .alu_op_o    (alu_op),
      .state_o     (state),
      .halt_o      (halt),
      .err_o       (err),
      .instr_cnt_o (instr_cnt),
      .cycle_cnt_o (cycle_cnt)
   );

   always #5 clk = ~clk;

   cyc_t        plan_q[$];
   cyc_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned m_cycles = 0;
   int unsigned m_instrs = 0;
   bit          m_err    = 1'b0;

   function automatic bit is_legal(input logic [5:0] o);
      return o inside {6'd0, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd13, 6'd35, 6'd43};
   endfunction

   function automatic logic [3:0] exp_aluop(input logic [5:0] o);
      case (o)
         6'd0:               return 4'b0010;
         6'd4, 6'd5:         return 4'b0001;
         6'd10:              return 4'b0011;
         6'd9:               return 4'b0101;
         6'd13:              return 4'b0100;
         default:            return 4'b0000;
      endcase
   endfunction

   function automatic cyc_t rnd_cyc();
      cyc_t c;
      c       = '{default: '0};
      c.ready = 1'($urandom_range(0, 1));
      c.zero  = 1'($urandom_range(0, 1));
      c.op    = 6'($urandom_range(0, 63));
      return c;
   endfunction

   task automatic emit(input cyc_t c, input bit retire);
      c.halt = (c.st == 3'd7);
      c.err  = m_err;
      c.icnt = PERF ? m_instrs : 32'd0;
      c.ccnt = PERF ? m_cycles : 32'd0;
      c.chk  = !c.rst;
      plan_q.push_back(c);
      if (c.rst) begin
         m_cycles = 0;
         m_instrs = 0;
         m_err    = 1'b0;
      end else begin
         m_cycles++;
         if (retire) m_instrs++;
      end
   endtask

   task automatic plan_reset();
      cyc_t c;
      c     = rnd_cyc();
      c.rst = 1'b1;
      emit(c, 1'b0);
   endtask

   task automatic plan_halt(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c    = rnd_cyc();
         c.st = 3'd7;
         emit(c, 1'b0);
      end
   endtask

   // One instruction from fetch to retire; waits count not-ready cycles before the ready one.
   task automatic plan_instr(input logic [5:0] o, input logic z, input int if_wait,
                             input int mem_wait, input bit rst_mem, output bit halted);
      cyc_t c;
      halted = 1'b0;
      for (int i = 0; i <= if_wait; i++) begin
         c       = rnd_cyc();
         c.st    = 3'd0;
         c.ready = (i == if_wait);
         c.ctl   = MREQ | (c.ready ? (IRW | PCW) : 11'd0);
         emit(c, 1'b0);
         if (!c.ready && i + 1 == int'(TB_TIMEOUT)) begin
            m_err  = 1'b1;
            halted = 1'b1;
            return;
         end
      end
      c    = rnd_cyc();
      c.st = 3'd1;
      c.op = o;
      emit(c, 1'b0);
      if (o == 6'h3F) begin
         halted = 1'b1;
         return;
      end
      if (!is_legal(o)) begin
         m_err  = 1'b1;
         halted = 1'b1;
         return;
      end
      c      = rnd_cyc();
      c.st   = 3'd2;
      c.op   = o;
      c.zero = z;
      c.aop  = exp_aluop(o);
      if (o inside {6'd8, 6'd9, 6'd10, 6'd13, 6'd35, 6'd43}) c.ctl |= ASRC;
      if (!(o == 6'd9 || o == 6'd13)) c.ctl |= SEXT;
      if (o == 6'd4 || o == 6'd5) begin
         if ((o == 6'd4 && z) || (o == 6'd5 && !z)) c.ctl |= PCW | PCSRC;
         emit(c, 1'b1);
         return;
      end
      emit(c, 1'b0);
      if (o == 6'd35 || o == 6'd43) begin
         for (int i = 0; i <= mem_wait; i++) begin
            c       = rnd_cyc();
            c.st    = 3'd3;
            c.op    = o;
            c.ready = (i == mem_wait);
            c.ctl   = MREQ | MSEL | ((o == 6'd43) ? MWE : 11'd0);
            if (rst_mem) begin
               c.rst = 1'b1;
               emit(c, 1'b0);
               return;
            end
            emit(c, c.ready && o == 6'd43);
            if (c.ready && o == 6'd43) return;
            if (!c.ready && i + 1 == int'(TB_TIMEOUT)) begin
               m_err  = 1'b1;
               halted = 1'b1;
               return;
            end
         end
      end
      c     = rnd_cyc();
      c.st  = 3'd4;
      c.op  = o;
      c.ctl = REGW | ((o == 6'd0) ? RDST : 11'd0) | ((o == 6'd35) ? M2R : 11'd0);
      emit(c, 1'b1);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      cyc_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         if (e.chk) begin
            check("state", 32'(state), 32'(e.st));
            check("ctrl", 32'({bus.mem_req, bus.mem_sel, bus.mem_we, ir_write, pc_write, pc_src,
                               reg_write, reg_dst, mem_to_reg, alu_src, sign_ext}), 32'(e.ctl));
            check("alu_op", 32'(alu_op), 32'(e.aop));
            check("halt_err", 32'({halt, err}), 32'({e.halt, e.err}));
            check("instr_cnt", instr_cnt, e.icnt);
            check("cycle_cnt", cycle_cnt, e.ccnt);
         end
      end
   end

   initial begin
      bit          h;
      cyc_t        c;
      logic [5:0]  o;
      int          r, iw, mw;
      logic [5:0]  legal_ops [9];
      legal_ops = '{6'd0, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd13, 6'd35, 6'd43};

      rst            = 1'b1;
      op             = 6'd0;
      zero           = 1'b0;
      bus.mem_ready  = 1'b0;

      // Directed scenarios
      plan_reset();
      plan_instr(6'd0, 1'b0, 0, 0, 1'b0, h);
      plan_instr(6'd4, 1'b1, 0, 0, 1'b0, h);
      plan_instr(6'd5, 1'b1, 0, 0, 1'b0, h);
      plan_instr(6'd4, 1'b0, 0, 0, 1'b0, h);
      plan_instr(6'd5, 1'b0, 0, 0, 1'b0, h);
      plan_instr(6'd35, 1'b0, 0, 3, 1'b0, h);
      plan_instr(6'd43, 1'b0, int'(TB_TIMEOUT) - 1, 0, 1'b0, h);
      plan_instr(6'd8, 1'b0, 100, 0, 1'b0, h);
      plan_halt(5);
      plan_reset();
      plan_instr(6'd35, 1'b0, 0, 100, 1'b0, h);
      plan_halt(3);
      plan_reset();
      plan_instr(6'h02, 1'b0, 0, 0, 1'b0, h);
      plan_halt(3);
      plan_reset();
      plan_instr(6'h3F, 1'b0, 1, 0, 1'b0, h);
      plan_halt(3);
      plan_reset();
      plan_instr(6'd0, 1'b0, 0, 0, 1'b0, h);
      plan_instr(6'd43, 1'b0, 0, 2, 1'b1, h);
      plan_instr(6'd13, 1'b0, 0, 0, 1'b0, h);

      // Randomized program
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 90) begin
            o = legal_ops[$urandom_range(0, 8)];
         end else if (r < 94) begin
            o = 6'h3F;
         end else begin
            do o = 6'($urandom_range(0, 63)); while (is_legal(o) || o == 6'h3F);
         end
         iw = int'($urandom_range(0, 2));
         mw = int'($urandom_range(0, 2));
         if ($urandom_range(0, 19) == 0) iw = int'(TB_TIMEOUT) - 1 + int'($urandom_range(0, 2));
         if ($urandom_range(0, 19) == 0) mw = int'(TB_TIMEOUT) - 1 + int'($urandom_range(0, 2));
         plan_instr(o, 1'($urandom_range(0, 1)), iw, mw, ($urandom_range(0, 49) == 0), h);
         if (h) begin
            plan_halt(int'($urandom_range(1, 4)));
            plan_reset();
         end
      end

      while (plan_q.size() != 0) begin
         c = plan_q.pop_front();
         @(posedge clk);
         #1;
         rst           = c.rst;
         bus.mem_ready = c.ready;
         zero          = c.zero;
         op            = c.op;
         sb_q.push_back(c);
      end

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
